// File: rtl/frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_pkg
// Purpose  : Shared types, screen geometry and pixel helpers for the
//            multi-buffered renderer-to-HDMI frame buffer.
// Revision : 1.0  initial release
// ============================================================================
package frame_buffer_pkg;

    // Default renderer resolution (1280x720 downscaled by 4)
    localparam int SCREEN_W = 1280 >> 2;
    localparam int SCREEN_H = 720 >> 2;
    localparam int FB_DEPTH = SCREEN_W * SCREEN_H;

    typedef logic [1:0] fb_idx_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Widen each channel by replicating its MSBs so full-scale maps to 0xFF
    function automatic logic [23:0] rgb565_to_rgb888(input rgb565_t p);
        return {p.r, p.r[4:2], p.g, p.g[5:4], p.b, p.b[4:2]};
    endfunction

    // With banks 0..2, the bank that is neither a nor b
    function automatic fb_idx_t fb_third_idx(input fb_idx_t a, input fb_idx_t b);
        return fb_idx_t'(2'd3 - a - b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_swap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fb_swap_ctrl
// Purpose  : Bank bookkeeping for the frame buffer: back/front indices,
//            pending and free banks, writer back-pressure and swap pulse.
//            FB_STATS_EN adds a saturating repeated-frame counter.
// Revision : 1.0  initial release
// ============================================================================
module fb_swap_ctrl
    import frame_buffer_pkg::*;
#(
    parameter int NUM_BUFFERS = 2
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        ray_valid_in,
    input  logic        ray_last_pixel_in,
    input  logic        video_last_pixel_in,
    output fb_idx_t     wr_idx_out,
    output fb_idx_t     rd_idx_out,
    output logic        ray_ready_out,
    output logic        frame_swap_out,
    output logic [15:0] repeat_count_out
);

    fb_idx_t r_wr_idx, r_rd_idx, w_wr_idx_nxt, w_rd_idx_nxt;
    logic    r_frame_swap, w_swap, w_ready, w_last_acc;

    assign w_last_acc = ray_valid_in & w_ready & ray_last_pixel_in;

    // Bank indices and the swap pulse, which lands with the new front index
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_idx     <= 2'd0;
            r_rd_idx     <= 2'd1;
            r_frame_swap <= 1'b0;
        end else begin
            r_wr_idx     <= w_wr_idx_nxt;
            r_rd_idx     <= w_rd_idx_nxt;
            r_frame_swap <= w_swap;
        end
    end

    generate
        if (NUM_BUFFERS == 2) begin : g_double
            localparam logic [0:0] c_st_writing   = 1'b0;
            localparam logic [0:0] c_st_wait_swap = 1'b1;
            logic [0:0] r_state, w_state_nxt;

            // State register
            always_ff @(posedge pixel_clk_in or posedge rst_in) begin
                if (rst_in) r_state <= c_st_writing;
                else        r_state <= w_state_nxt;
            end

            // Next state: a finished frame waits for the video frame end,
            // unless both ends coincide, in which case it swaps at once
            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    c_st_writing:   if (w_last_acc && !video_last_pixel_in) w_state_nxt = c_st_wait_swap;
                    c_st_wait_swap: if (video_last_pixel_in)               w_state_nxt = c_st_writing;
                    default:        w_state_nxt = c_st_writing;
                endcase
            end

            assign w_ready = (r_state == c_st_writing);

            // Outputs: exchange the two banks on a swap
            always_comb begin
                w_swap       = video_last_pixel_in && ((r_state == c_st_wait_swap) || w_last_acc);
                w_wr_idx_nxt = r_wr_idx;
                w_rd_idx_nxt = r_rd_idx;
                if (w_swap) begin
                    w_wr_idx_nxt = r_rd_idx;
                    w_rd_idx_nxt = r_wr_idx;
                end
            end
        end else if (NUM_BUFFERS == 3) begin : g_triple
            logic    r_pend_valid, w_pend_valid_nxt;
            fb_idx_t r_pend_idx, w_pend_idx_nxt;

            // Pending-frame register
            always_ff @(posedge pixel_clk_in or posedge rst_in) begin
                if (rst_in) begin
                    r_pend_valid <= 1'b0;
                    r_pend_idx   <= 2'd0;
                end else begin
                    r_pend_valid <= w_pend_valid_nxt;
                    r_pend_idx   <= w_pend_idx_nxt;
                end
            end

            // Three banks always leave the writer a bank to move to
            assign w_ready = 1'b1;

            // Bank rotation: finished frames become pending, newer pending
            // frames displace older ones, frame end promotes pending to front
            always_comb begin
                w_wr_idx_nxt     = r_wr_idx;
                w_rd_idx_nxt     = r_rd_idx;
                w_pend_valid_nxt = r_pend_valid;
                w_pend_idx_nxt   = r_pend_idx;
                w_swap           = 1'b0;
                if (w_last_acc && video_last_pixel_in) begin
                    w_swap           = 1'b1;
                    w_rd_idx_nxt     = r_wr_idx;
                    w_wr_idx_nxt     = r_rd_idx;
                    w_pend_valid_nxt = 1'b0;
                end else if (w_last_acc) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_idx_nxt   = r_wr_idx;
                    w_wr_idx_nxt     = r_pend_valid ? r_pend_idx : fb_third_idx(r_wr_idx, r_rd_idx);
                end else if (video_last_pixel_in && r_pend_valid) begin
                    w_swap           = 1'b1;
                    w_rd_idx_nxt     = r_pend_idx;
                    w_pend_valid_nxt = 1'b0;
                end
            end
        end else begin : g_bad_num_buffers
            $error("fb_swap_ctrl: NUM_BUFFERS must be 2 or 3");
        end
    endgenerate

`ifdef FB_STATS_EN
    logic        w_repeat;
    logic [15:0] r_repeat_count;
    assign w_repeat = video_last_pixel_in & ~w_swap;

    // Saturating count of frame ends that had nothing new to show
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in)                                    r_repeat_count <= 16'd0;
        else if (w_repeat && r_repeat_count != 16'hFFFF) r_repeat_count <= r_repeat_count + 16'd1;
    end
    assign repeat_count_out = r_repeat_count;
`else
    assign repeat_count_out = 16'd0;
`endif

    assign wr_idx_out     = r_wr_idx;
    assign rd_idx_out     = r_rd_idx;
    assign ray_ready_out  = w_ready;
    assign frame_swap_out = r_frame_swap;

endmodule
`default_nettype wire

// File: rtl/xilinx_single_port_ram_read_first.sv
`default_nettype none
// ============================================================================
// Module   : xilinx_single_port_ram_read_first
// Purpose  : Single-port block RAM, read-first, with optional output register
//            (HIGH_PERFORMANCE = 2-cycle read, LOW_LATENCY = 1-cycle read).
// Revision : 1.0  initial release
// ============================================================================
module xilinx_single_port_ram_read_first #(
    parameter int    RAM_WIDTH       = 16,
    parameter int    RAM_DEPTH       = 57600,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         ena,
    output logic [RAM_WIDTH-1:0]         douta
);

    logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] r_ram_data;

    // Array access: old data is returned on a write (read-first)
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) r_mem[addra] <= dina;
            r_ram_data <= r_mem[addra];
        end
    end

    generate
        if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_out_reg
            logic [RAM_WIDTH-1:0] r_douta;
            // Output register stage
            always_ff @(posedge clka) begin
                if (ena) r_douta <= r_ram_data;
            end
            assign douta = r_douta;
        end else begin : g_no_out_reg
            assign douta = r_ram_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multi_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : multi_frame_buffer
// Purpose  : Double/triple frame buffer between the ray renderer (RGB565,
//            random-order writes) and the HDMI path (upscaled RGB888 reads).
//            FB_STATS_EN enables the repeated-frame counter.
// Revision : 1.0  initial release
// ============================================================================
module multi_frame_buffer
    import frame_buffer_pkg::*;
#(
    parameter int PIXEL_WIDTH        = 16,
    parameter int FULL_SCREEN_WIDTH  = 1280,
    parameter int FULL_SCREEN_HEIGHT = 720,
    parameter int SCALE_SHIFT        = 2,
    parameter int NUM_BUFFERS        = 2,
    parameter int RAM_LATENCY        = 2
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   ray_valid_in,
    input  logic [15:0]            ray_address_in,
    input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
    input  logic                   ray_last_pixel_in,
    input  logic                   video_last_pixel_in,
    output logic                   ray_ready_out,
    output logic [23:0]            rgb_out,
    output logic                   rgb_valid_out,
    output logic                   frame_swap_out,
    output logic [15:0]            repeat_count_out
);

    localparam int    c_screen_w = FULL_SCREEN_WIDTH >> SCALE_SHIFT;
    localparam int    c_screen_h = FULL_SCREEN_HEIGHT >> SCALE_SHIFT;
    localparam int    c_fb_depth = c_screen_w * c_screen_h;
    localparam int    c_addr_w   = $clog2(c_fb_depth);
    localparam string c_ram_mode = (RAM_LATENCY == 2) ? "HIGH_PERFORMANCE" : "LOW_LATENCY";

    fb_idx_t w_wr_idx, w_rd_idx;

    fb_swap_ctrl #(.NUM_BUFFERS(NUM_BUFFERS)) u_swap_ctrl (
        .pixel_clk_in        (pixel_clk_in),
        .rst_in              (rst_in),
        .ray_valid_in        (ray_valid_in),
        .ray_last_pixel_in   (ray_last_pixel_in),
        .video_last_pixel_in (video_last_pixel_in),
        .wr_idx_out          (w_wr_idx),
        .rd_idx_out          (w_rd_idx),
        .ray_ready_out       (ray_ready_out),
        .frame_swap_out      (frame_swap_out),
        .repeat_count_out    (repeat_count_out)
    );

    // Write side: out-of-range addresses are dropped, and reset aborts writes
    logic                w_wr_en;
    logic [c_addr_w-1:0] w_wr_addr;
    assign w_wr_addr = c_addr_w'(ray_address_in);
    assign w_wr_en   = ray_valid_in & ray_ready_out & ~rst_in
                     & (32'(ray_address_in) < c_fb_depth);

    // Read side: blanking reads are parked on address 0 so the product
    // below can never leave the buffer
    logic                w_active;
    logic [c_addr_w-1:0] w_rd_addr;
    assign w_active  = (32'(hcount_in) < FULL_SCREEN_WIDTH) && (32'(vcount_in) < FULL_SCREEN_HEIGHT);
    assign w_rd_addr = w_active ? c_addr_w'(hcount_in >> SCALE_SHIFT)
                                  + c_addr_w'(c_screen_w) * c_addr_w'(vcount_in >> SCALE_SHIFT)
                                : '0;

    logic [PIXEL_WIDTH-1:0] w_bank_dout [4];

    generate
        if (RAM_LATENCY != 1 && RAM_LATENCY != 2) begin : g_bad_latency
            $error("multi_frame_buffer: RAM_LATENCY must be 1 or 2");
        end
        for (genvar g = 0; g < 4; g++) begin : g_bank
            if (g < NUM_BUFFERS) begin : g_ram
                logic w_is_wr;
                assign w_is_wr = (w_wr_idx == fb_idx_t'(g));
                xilinx_single_port_ram_read_first #(
                    .RAM_WIDTH       (PIXEL_WIDTH),
                    .RAM_DEPTH       (c_fb_depth),
                    .RAM_PERFORMANCE (c_ram_mode)
                ) u_ram (
                    .addra (w_is_wr ? w_wr_addr : w_rd_addr),
                    .dina  (ray_pixel_in),
                    .clka  (pixel_clk_in),
                    .wea   (w_wr_en & w_is_wr),
                    .ena   (1'b1),
                    .douta (w_bank_dout[g])
                );
            end else begin : g_unused
                assign w_bank_dout[g] = '0;
            end
        end
    endgenerate

    logic    r_act_pipe [RAM_LATENCY];
    fb_idx_t r_sel_pipe [RAM_LATENCY];

    // Carry the active flag and source bank alongside the RAM read latency
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                r_act_pipe[i] <= 1'b0;
                r_sel_pipe[i] <= 2'd0;
            end
        end else begin
            r_act_pipe[0] <= w_active;
            r_sel_pipe[0] <= w_rd_idx;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_act_pipe[i] <= r_act_pipe[i-1];
                r_sel_pipe[i] <= r_sel_pipe[i-1];
            end
        end
    end

    assign rgb_valid_out = r_act_pipe[RAM_LATENCY-1];
    assign rgb_out       = rgb_valid_out
                         ? rgb565_to_rgb888(rgb565_t'(w_bank_dout[r_sel_pipe[RAM_LATENCY-1]]))
                         : 24'h0;

endmodule
`default_nettype wire

// File: tb/tb_multi_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_frame_buffer
// Purpose  : Directed bench driving a double- and a triple-buffered instance
//            from the same stimulus, with hand-computed expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_frame_buffer;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        ray_valid_in;
    logic [15:0] ray_address_in;
    logic [15:0] ray_pixel_in;
    logic        ray_last_pixel_in;
    logic        video_last_pixel_in;

    logic        d2_ready, d2_valid, d2_swap, d3_ready, d3_valid, d3_swap;
    logic [23:0] d2_rgb, d3_rgb;
    logic [15:0] d2_rep, d3_rep;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef FB_STATS_EN
    localparam logic [15:0] EXP_REP = 16'd2;
`else
    localparam logic [15:0] EXP_REP = 16'd0;
`endif

    always #5 pixel_clk_in = ~pixel_clk_in;

    multi_frame_buffer #(.NUM_BUFFERS(2)) u_dut2 (
        .pixel_clk_in(pixel_clk_in), .rst_in(rst_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .ray_valid_in(ray_valid_in), .ray_address_in(ray_address_in),
        .ray_pixel_in(ray_pixel_in), .ray_last_pixel_in(ray_last_pixel_in),
        .video_last_pixel_in(video_last_pixel_in),
        .ray_ready_out(d2_ready), .rgb_out(d2_rgb), .rgb_valid_out(d2_valid),
        .frame_swap_out(d2_swap), .repeat_count_out(d2_rep)
    );

    multi_frame_buffer #(.NUM_BUFFERS(3)) u_dut3 (
        .pixel_clk_in(pixel_clk_in), .rst_in(rst_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .ray_valid_in(ray_valid_in), .ray_address_in(ray_address_in),
        .ray_pixel_in(ray_pixel_in), .ray_last_pixel_in(ray_last_pixel_in),
        .video_last_pixel_in(video_last_pixel_in),
        .ray_ready_out(d3_ready), .rgb_out(d3_rgb), .rgb_valid_out(d3_valid),
        .frame_swap_out(d3_swap), .repeat_count_out(d3_rep)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk_in);
        #1;
    endtask

    task automatic write_px(input logic [15:0] a, input logic [15:0] p, input logic last);
        ray_valid_in      = 1'b1;
        ray_address_in    = a;
        ray_pixel_in      = p;
        ray_last_pixel_in = last;
        tick();
        ray_valid_in      = 1'b0;
        ray_last_pixel_in = 1'b0;
    endtask

    task automatic video_end();
        video_last_pixel_in = 1'b1;
        tick();
        video_last_pixel_in = 1'b0;
    endtask

    task automatic look(input int h, input int v);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        tick();
        tick();
    endtask

    initial begin
        rst_in = 1'b1;
        hcount_in = 11'd1280; vcount_in = 10'd0;
        ray_valid_in = 1'b0; ray_address_in = 16'd0; ray_pixel_in = 16'd0;
        ray_last_pixel_in = 1'b0; video_last_pixel_in = 1'b0;
        tick(); tick();

        // Reset values
        check("rst_d2_ready", 32'(d2_ready), 32'd1);
        check("rst_d3_ready", 32'(d3_ready), 32'd1);
        check("rst_d2_rgb",   32'(d2_rgb),   32'd0);
        check("rst_d2_valid", 32'(d2_valid), 32'd0);
        check("rst_d2_swap",  32'(d2_swap),  32'd0);
        check("rst_d2_rep",   32'(d2_rep),   32'd0);
        rst_in = 1'b0;
        tick();

        // Read latency and active-region boundaries
        hcount_in = 11'd0; vcount_in = 10'd0;
        tick();
        check("lat1_d2_valid", 32'(d2_valid), 32'd0);
        tick();
        check("lat2_d2_valid", 32'(d2_valid), 32'd1);
        check("lat2_d3_valid", 32'(d3_valid), 32'd1);
        look(1280, 0);
        check("h1280_d2_valid", 32'(d2_valid), 32'd0);
        check("h1280_d2_rgb",   32'(d2_rgb),   32'd0);
        check("h1280_d3_rgb",   32'(d3_rgb),   32'd0);
        look(0, 720);
        check("v720_d2_valid", 32'(d2_valid), 32'd0);
        look(1279, 719);
        check("corner_d2_valid", 32'(d2_valid), 32'd1);

        // Double buffer: frame end, back-pressure, swap
        hcount_in = 11'd0; vcount_in = 10'd0;
        write_px(16'd0, 16'hFFFF, 1'b0);
        write_px(16'd1, 16'h0000, 1'b1);
        check("t2_d2_ready_drop", 32'(d2_ready), 32'd0);
        check("t2_d3_ready_hold", 32'(d3_ready), 32'd1);
        write_px(16'd0, 16'h0000, 1'b0);
        check("t2_d2_ready_still0", 32'(d2_ready), 32'd0);
        check("t2_d2_no_early_swap", 32'(d2_swap), 32'd0);
        video_end();
        check("t2_d2_swap", 32'(d2_swap), 32'd1);
        check("t2_d3_swap", 32'(d3_swap), 32'd1);
        tick();
        check("t2_d2_swap_once", 32'(d2_swap),  32'd0);
        check("t2_d2_ready_back", 32'(d2_ready), 32'd1);
        look(0, 0);
        check("t2_d2_px00", 32'(d2_rgb), 32'h00FFFFFF);
        look(3, 3);
        check("t2_d2_px33", 32'(d2_rgb), 32'h00FFFFFF);
        check("t2_d3_px33", 32'(d3_rgb), 32'h00FFFFFF);
        look(4, 0);
        check("t2_d2_px40", 32'(d2_rgb), 32'h00000000);
        check("t2_d3_px40", 32'(d3_rgb), 32'h00000000);

        // Repeated frames: no swap, counter (when built)
        video_end();
        check("t3_d2_noswap1", 32'(d2_swap), 32'd0);
        tick();
        video_end();
        check("t3_d3_noswap2", 32'(d3_swap), 32'd0);
        tick();
        check("t3_d2_rep", 32'(d2_rep), 32'(EXP_REP));
        check("t3_d3_rep", 32'(d3_rep), 32'(EXP_REP));
        look(0, 0);
        check("t3_d2_front_kept", 32'(d2_rgb), 32'h00FFFFFF);

        // Triple buffer: two frames before one video frame end
        write_px(16'd0, 16'hF800, 1'b1);
        check("t4_d3_ready_a", 32'(d3_ready), 32'd1);
        write_px(16'd0, 16'h07E0, 1'b1);
        check("t4_d3_ready_b", 32'(d3_ready), 32'd1);
        tick();
        check("t4_d3_ready_c", 32'(d3_ready), 32'd1);
        video_end();
        check("t4_d3_swap", 32'(d3_swap), 32'd1);
        check("t4_d2_swap", 32'(d2_swap), 32'd1);
        look(0, 0);
        check("t4_d3_newest", 32'(d3_rgb), 32'h0000FF00);
        check("t4_d2_first",  32'(d2_rgb), 32'h00FF0000);

        // Renderer and video frame ends in the same cycle
        ray_valid_in = 1'b1; ray_address_in = 16'd0; ray_pixel_in = 16'h001F;
        ray_last_pixel_in = 1'b1; video_last_pixel_in = 1'b1;
        tick();
        ray_valid_in = 1'b0; ray_last_pixel_in = 1'b0; video_last_pixel_in = 1'b0;
        check("t5_d2_swap",  32'(d2_swap),  32'd1);
        check("t5_d3_swap",  32'(d3_swap),  32'd1);
        check("t5_d2_ready", 32'(d2_ready), 32'd1);
        look(0, 0);
        check("t5_d2_px", 32'(d2_rgb), 32'h000000FF);
        check("t5_d3_px", 32'(d3_rgb), 32'h000000FF);

        // Last in-range address, dropped out-of-range write
        write_px(16'd57599, 16'h07E0, 1'b0);
        write_px(16'd57600, 16'h1234, 1'b1);
        video_end();
        check("t6_d2_swap", 32'(d2_swap), 32'd1);
        look(1279, 719);
        check("t6_d2_lastpx", 32'(d2_rgb), 32'h0000FF00);
        check("t6_d3_lastpx", 32'(d3_rgb), 32'h0000FF00);
        look(0, 0);
        check("t6_d2_bank1", 32'(d2_rgb), 32'h00FF0000);
        check("t6_d3_bank1", 32'(d3_rgb), 32'h0000FF00);

        // Move the front buffer off bank 1 before resetting
        write_px(16'd2, 16'h001F, 1'b1);
        video_end();
        look(0, 0);
        check("t6_d2_bank0", 32'(d2_rgb), 32'h000000FF);
        check("t6_d3_bank0", 32'(d3_rgb), 32'h00FFFFFF);
        video_end();
        check("t6_d2_rep3", 32'(d2_rep), 32'(EXP_REP == 16'd0 ? 16'd0 : 16'd3));

        // Asynchronous reset mid-frame with a write in flight
        ray_valid_in = 1'b1; ray_address_in = 16'd1; ray_pixel_in = 16'hF800;
        #1 rst_in = 1'b1;
        #1;
        check("t6_rst_d2_rgb",   32'(d2_rgb),   32'd0);
        check("t6_rst_d2_valid", 32'(d2_valid), 32'd0);
        check("t6_rst_d2_swap",  32'(d2_swap),  32'd0);
        check("t6_rst_d2_rep",   32'(d2_rep),   32'd0);
        check("t6_rst_d2_ready", 32'(d2_ready), 32'd1);
        check("t6_rst_d3_rgb",   32'(d3_rgb),   32'd0);
        check("t6_rst_d3_valid", 32'(d3_valid), 32'd0);
        tick(); tick();
        check("t6_rst_hold_d3_valid", 32'(d3_valid), 32'd0);
        ray_valid_in = 1'b0;
        rst_in = 1'b0;
        tick();

        // Front is bank 1 again; RAM contents survived
        look(0, 0);
        check("t6_post_d2_rd1", 32'(d2_rgb), 32'h00FF0000);
        check("t6_post_d3_rd1", 32'(d3_rgb), 32'h0000FF00);

        // Writer is back on bank 0; the write during reset never landed
        write_px(16'd0, 16'h1234, 1'b1);
        video_end();
        check("t6_post_d3_swap", 32'(d3_swap), 32'd1);
        look(0, 0);
        check("t6_post_d2_wr0", 32'(d2_rgb), 32'h001045A5);
        check("t6_post_d3_wr0", 32'(d3_rgb), 32'h001045A5);
        look(4, 0);
        check("t6_abort_d2", 32'(d2_rgb), 32'h00000000);
        check("t6_abort_d3", 32'(d3_rgb), 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
